// File: rtl/or_gate_pkg.sv
// or_gate_pkg: default widths and counter ceiling for the or_gate library cell.
package or_gate_pkg;
  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};
endpackage

// File: rtl/or_gate_if.sv
// or_gate_if: operand/result bundle for or_gate; act_cnt/cnt_clr exist only with OR_GATE_STATS_EN.
interface or_gate_if import or_gate_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
`ifdef OR_GATE_STATS_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_q;
  logic [WIDTH-1:0] y_rise;
`ifdef OR_GATE_STATS_EN
  logic [CNT_W-1:0] act_cnt;
  logic cnt_clr;
  modport master(output A, B, cnt_clr, input Y, Y_q, y_rise, act_cnt);
  modport slave(input A, B, cnt_clr, output Y, Y_q, y_rise, act_cnt);
`else
  modport master(output A, B, input Y, Y_q, y_rise);
  modport slave(input A, B, output Y, Y_q, y_rise);
`endif
endinterface

// File: rtl/or_gate_sat_cnt.sv
// or_gate_sat_cnt: counter with enable and sync clear that sticks at all-ones.
module or_gate_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/or_gate.sv
// or_gate: Y = A | B plus clocked probe path (Y_q, y_rise); OR_GATE_STATS_EN adds act_cnt.
module or_gate import or_gate_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
`ifdef OR_GATE_STATS_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input logic     clk,
  input logic     rst_n,
  or_gate_if.slave io
);
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_rise;
  assign io.Y = io.A | io.B;
  assign io.Y_q = y_q;
  assign io.y_rise = y_rise;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y_q <= '0;
      y_rise <= '0;
    end else begin
      y_q <= io.Y;
      y_rise <= io.Y & ~y_q;
    end
`ifdef OR_GATE_STATS_EN
  or_gate_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .en(|io.Y),
    .clr(io.cnt_clr),
    .q(io.act_cnt)
  );
`endif
endmodule

// File: tb/tb_or_gate.sv
// tb_or_gate: directed scoreboard bench for or_gate at WIDTH=1 and WIDTH=4 (CNT_W=4 with OR_GATE_STATS_EN).
module tb_or_gate;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  logic [3:0] sb[$];
`ifdef OR_GATE_STATS_EN
  or_gate_if #(.WIDTH(1), .CNT_W(4)) i1 ();
  or_gate_if #(.WIDTH(4), .CNT_W(4)) i4 ();
  or_gate #(.WIDTH(1), .CNT_W(4)) d1 (.clk(clk), .rst_n(rst_n), .io(i1.slave));
  or_gate #(.WIDTH(4), .CNT_W(4)) d4 (.clk(clk), .rst_n(rst_n), .io(i4.slave));
`else
  or_gate_if #(.WIDTH(1)) i1 ();
  or_gate_if #(.WIDTH(4)) i4 ();
  or_gate #(.WIDTH(1)) d1 (.clk(clk), .rst_n(rst_n), .io(i1.slave));
  or_gate #(.WIDTH(4)) d4 (.clk(clk), .rst_n(rst_n), .io(i4.slave));
`endif

  task automatic push(input logic [3:0] e);
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs);
    logic [3:0] e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty, observed %b", tag, obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic tick();
    clk = 1'b1;
    #5 clk = 1'b0;
    #5;
  endtask

  initial begin
    logic [1:0] ab [4];
    logic [3:0] ty [4];
    ab[0] = 2'b00; ab[1] = 2'b10; ab[2] = 2'b01; ab[3] = 2'b11;
    ty[0] = 4'h0;  ty[1] = 4'h1;  ty[2] = 4'h1;  ty[3] = 4'h1;
    i1.A = 1'b0; i1.B = 1'b0; i4.A = 4'h0; i4.B = 4'h0;
`ifdef OR_GATE_STATS_EN
    i1.cnt_clr = 1'b0; i4.cnt_clr = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    push(4'h0); chk("rst_yq", {3'b0, i1.Y_q});
    push(4'h0); chk("rst_rise", {3'b0, i1.y_rise});
    push(4'h0); chk("rst_yq4", i4.Y_q);
`ifdef OR_GATE_STATS_EN
    push(4'h0); chk("rst_cnt", i1.act_cnt);
`endif
    for (int i = 0; i < 4; i++) begin
      i1.A = ab[i][1]; i1.B = ab[i][0];
      push(ty[i]);
      #10 chk($sformatf("tt_%b", ab[i]), {3'b0, i1.Y});
    end
    i1.A = 1'b1; i1.B = 1'bx;
    push(4'h1); #1 chk("x_1or", {3'b0, i1.Y});
    i1.A = 1'b0;
    push({3'b0, 1'bx}); #1 chk("x_0or", {3'b0, i1.Y});
    i1.A = 1'b1; i1.B = 1'b0;
    #4 rst_n = 1'b1;
    #5 tick();
    push(4'h1); chk("reg_yq", {3'b0, i1.Y_q});
    push(4'h1); chk("reg_rise", {3'b0, i1.y_rise});
    tick();
    push(4'h0); chk("rise_drop", {3'b0, i1.y_rise});
    push(4'h1); chk("reg_hold", {3'b0, i1.Y_q});
`ifdef OR_GATE_STATS_EN
    push(4'h2); chk("cnt_2", i1.act_cnt);
`endif
    rst_n = 1'b0;
    #1;
    push(4'h0); chk("arst_yq", {3'b0, i1.Y_q});
    push(4'h1); chk("arst_y", {3'b0, i1.Y});
`ifdef OR_GATE_STATS_EN
    push(4'h0); chk("arst_cnt", i1.act_cnt);
`endif
    #4 rst_n = 1'b1;
    tick();
    push(4'h1); chk("rel_rise", {3'b0, i1.y_rise});
`ifdef OR_GATE_STATS_EN
    push(4'h1); chk("cnt_1", i1.act_cnt);
    for (int i = 0; i < 14; i++) tick();
    push(4'hf); chk("cnt_15", i1.act_cnt);
    for (int i = 0; i < 5; i++) tick();
    push(4'hf); chk("cnt_sat", i1.act_cnt);
    i1.cnt_clr = 1'b1;
    tick();
    push(4'h0); chk("cnt_clr", i1.act_cnt);
    i1.cnt_clr = 1'b0; i1.A = 1'b0;
    tick();
    push(4'h0); chk("cnt_idle", i1.act_cnt);
    push(4'h0); chk("yq_fall", {3'b0, i1.Y_q});
    i1.A = 1'b1;
    tick();
    push(4'h1); chk("cnt_resume", i1.act_cnt);
`endif
    i4.A = 4'b1010; i4.B = 4'b0110;
    push(4'b1110); #1 chk("w4_y", i4.Y);
    push(4'b0000); chk("w4_yq_pre", i4.Y_q);
    tick();
    push(4'b1110); chk("w4_rise", i4.y_rise);
    push(4'b1110); chk("w4_yq", i4.Y_q);
    i4.A = 4'b0001; i4.B = 4'b0000;
    tick();
    push(4'b0001); chk("w4_rise2", i4.y_rise);
    push(4'b0001); chk("w4_yq2", i4.Y_q);
    tick();
    push(4'b0000); chk("w4_rise3", i4.y_rise);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
